// File: rtl/alu_req_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter/sequencer for the shared ALU: accept, issue one cycle, capture, respond.
// Optional ALU_ARB_FLAG_CHECK_EN reports a missing unit flag on RSP_ERR.
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ0_B,
  input  logic [3:0]            REQ0_FUN,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ1_B,
  input  logic [3:0]            REQ1_FUN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [1:0]            ALU_FUN,
  output logic                  ARITH_Enable,
  output logic                  LOGIC_Enable,
  output logic                  CMP_Enable,
  output logic                  SHIFT_Enable,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_FLAG,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP0_VALID,
  output logic                  RSP1_VALID,
  output logic                  RSP_ERR,
  output logic                  BUSY,
  output logic [15:0]           OP_COUNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                r_state;
  logic                  r_ptr;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [1:0]            r_alu_fun;
  logic [3:0]            r_en;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp0;
  logic                  r_rsp1;
  logic [15:0]           r_op_count;

  logic       w_idle;
  logic       w_any;
  logic       w_grant;
  logic [3:0] w_win_fun;
  logic [3:0] w_dec;

  // w_grant selects requester 1; the pointer only matters under contention
  assign w_idle    = (r_state == IDLE);
  assign w_any     = REQ0_VALID | REQ1_VALID;
  assign w_grant   = (REQ0_VALID & REQ1_VALID) ? r_ptr : REQ1_VALID;
  assign w_win_fun = w_grant ? REQ1_FUN : REQ0_FUN;
  assign w_dec     = 4'b0001 << w_win_fun[3:2];

  assign REQ0_READY = w_idle & ~w_grant & REQ0_VALID;
  assign REQ1_READY = w_idle &  w_grant & REQ1_VALID;

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fun  <= '0;
      r_en       <= '0;
      r_rsp_data <= '0;
      r_rsp0     <= 1'b0;
      r_rsp1     <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_en   <= '0;
      r_rsp0 <= 1'b0;
      r_rsp1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_a   <= w_grant ? REQ1_A : REQ0_A;
            r_alu_b   <= w_grant ? REQ1_B : REQ0_B;
            r_alu_fun <= w_win_fun[1:0];
            r_en      <= w_dec;
            r_id      <= w_grant;
            r_ptr     <= ~w_grant;
            r_state   <= ISSUE;
          end
        end
        ISSUE: r_state <= CAPTURE;
        CAPTURE: begin
          r_rsp_data <= ALU_OUT;
          r_rsp0     <= ~r_id;
          r_rsp1     <= r_id;
          r_op_count <= r_op_count + 16'd1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAG_CHECK_EN
  logic r_err;

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_err <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_err <= ~ALU_FLAG;
    end
  end

  assign RSP_ERR = r_err;
`else
  logic w_flag_unused;

  assign w_flag_unused = ALU_FLAG;
  assign RSP_ERR       = 1'b0;
`endif

  assign ALU_A        = r_alu_a;
  assign ALU_B        = r_alu_b;
  assign ALU_FUN      = r_alu_fun;
  assign ARITH_Enable = r_en[0];
  assign LOGIC_Enable = r_en[1];
  assign CMP_Enable   = r_en[2];
  assign SHIFT_Enable = r_en[3];
  assign RSP_DATA     = r_rsp_data;
  assign RSP0_VALID   = r_rsp0;
  assign RSP1_VALID   = r_rsp1;
  assign BUSY         = ~w_idle;
  assign OP_COUNT     = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_req_arbiter: registered ALU model, response scoreboard, scenario tasks.
module tb_alu_req_arbiter;

  logic        Clk;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [15:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic [15:0] ALU_A, ALU_B;
  logic [1:0]  ALU_FUN;
  logic        ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] ALU_OUT;
  logic        ALU_FLAG;
  logic [15:0] RSP_DATA;
  logic        RSP0_VALID, RSP1_VALID, RSP_ERR, BUSY;
  logic [15:0] OP_COUNT;

  typedef struct packed {logic [15:0] a; logic [15:0] b; logic [3:0] fun;} op_t;
  typedef struct packed {logic id; logic [15:0] data; logic err;} exp_t;

  exp_t        exp_q[$];
  op_t         ops0[$];
  op_t         ops1[$];
  int          grant_log[$];
  int          acc_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] exp_count = '0;
  logic        flag_ok   = 1'b1;
  exp_t        mon_e;
  logic [1:0]  unit_sel;
  logic        any_en;

  alu_req_arbiter #(.DATA_WIDTH(16)) dut (
    .Clk(Clk), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ARITH_Enable(ARITH_Enable), .LOGIC_Enable(LOGIC_Enable), .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .ALU_OUT(ALU_OUT), .ALU_FLAG(ALU_FLAG),
    .RSP_DATA(RSP_DATA), .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .OP_COUNT(OP_COUNT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] f_alu(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    logic [15:0] r;
    case (fun)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a + 16'd1;
      4'b0011: r = a - 16'd1;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~a;
      4'b1000: r = {15'd0, a == b};
      4'b1001: r = {15'd0, a > b};
      4'b1010: r = {15'd0, a < b};
      4'b1011: r = 16'd0;
      4'b1100: r = a >> 1;
      4'b1101: r = a << 1;
      4'b1110: r = b >> 1;
      default: r = b << 1;
    endcase
    return r;
  endfunction

  function automatic logic f_err(input logic ok);
`ifdef ALU_ARB_FLAG_CHECK_EN
    return ~ok;
`else
    return 1'b0 & ok;
`endif
  endfunction

  // Unit model: the selected unit is recovered from the enables, so a wrong decode shows up as wrong data.
  assign unit_sel = {CMP_Enable | SHIFT_Enable, LOGIC_Enable | SHIFT_Enable};
  assign any_en   = ARITH_Enable | LOGIC_Enable | CMP_Enable | SHIFT_Enable;

  always @(posedge Clk or negedge RST) begin
    if (!RST) begin
      ALU_OUT  <= '0;
      ALU_FLAG <= 1'b0;
    end else begin
      ALU_OUT  <= any_en ? f_alu(ALU_A, ALU_B, {unit_sel, ALU_FUN}) : 16'd0;
      ALU_FLAG <= any_en & flag_ok;
    end
  end

  always @(negedge Clk) begin
    if (RST && (RSP0_VALID || RSP1_VALID)) begin
      n_checks++;
      if (RSP0_VALID && RSP1_VALID) begin
        n_fail++;
        $display("FAIL rsp_onehot: RSP0_VALID=%b RSP1_VALID=%b, required only one", RSP0_VALID, RSP1_VALID);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: RSP%0d_VALID=1 data=%h, required no response", RSP1_VALID, RSP_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        exp_count = exp_count + 16'd1;
        if ({RSP1_VALID, RSP_DATA, RSP_ERR} !== {mon_e.id, mon_e.data, mon_e.err}) begin
          n_fail++;
          $display("FAIL rsp_data: got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                   RSP1_VALID, RSP_DATA, RSP_ERR, mon_e.id, mon_e.data, mon_e.err);
        end
      end
    end
  end

  // Drives ops0/ops1 through the handshakes, pushing expectations at each accept.
  task automatic drive_ops(input int max_cyc, output bit timed_out, output bit both_ready);
    int  i0 = 0;
    int  i1 = 0;
    int  n  = 0;
    bit  adv0 = 0;
    bit  adv1 = 0;
    timed_out  = 0;
    both_ready = 0;
    while (i0 < ops0.size() || i1 < ops1.size() || adv0 || adv1 || exp_q.size() > 0) begin
      if (n >= max_cyc) begin
        timed_out = 1;
        break;
      end
      @(negedge Clk);
      n++;
      if (adv0) begin i0++; adv0 = 0; end
      if (adv1) begin i1++; adv1 = 0; end
      REQ0_VALID = (i0 < ops0.size());
      REQ1_VALID = (i1 < ops1.size());
      if (REQ0_VALID) {REQ0_A, REQ0_B, REQ0_FUN} = ops0[i0];
      if (REQ1_VALID) {REQ1_A, REQ1_B, REQ1_FUN} = ops1[i1];
      #1;
      if (REQ0_READY && REQ1_READY) both_ready = 1;
      if (REQ0_READY) begin
        exp_q.push_back({1'b0, f_alu(REQ0_A, REQ0_B, REQ0_FUN), f_err(flag_ok)});
        grant_log.push_back(0);
        acc_cyc.push_back(cyc);
        adv0 = 1;
      end
      if (REQ1_READY) begin
        exp_q.push_back({1'b1, f_alu(REQ1_A, REQ1_B, REQ1_FUN), f_err(flag_ok)});
        grant_log.push_back(1);
        acc_cyc.push_back(cyc);
        adv1 = 1;
      end
    end
    REQ0_VALID = 0;
    REQ1_VALID = 0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    RST = 0;
    {REQ0_VALID, REQ1_VALID} = '0;
    {REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_FUN, REQ1_FUN} = '0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable} !== 4'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b, required 0000", {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable});
    end
    n_checks++;
    if ({ALU_A, ALU_B, ALU_FUN} !== 34'd0) begin
      n_fail++; $display("FAIL reset_alu_bus: got A=%h B=%h FUN=%b, required 0", ALU_A, ALU_B, ALU_FUN);
    end
    n_checks++;
    if ({RSP_DATA, RSP0_VALID, RSP1_VALID, RSP_ERR, BUSY, OP_COUNT} !== 36'd0) begin
      n_fail++; $display("FAIL reset_status: got data=%h v0=%b v1=%b err=%b busy=%b cnt=%h, required 0",
                         RSP_DATA, RSP0_VALID, RSP1_VALID, RSP_ERR, BUSY, OP_COUNT);
    end
    REQ0_VALID = 1;
    #1;
    n_checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 10", {REQ0_READY, REQ1_READY});
    end
    REQ0_VALID = 0;
    @(negedge Clk);
    RST = 1;
  endtask

  task automatic test_single();
    @(negedge Clk);
    REQ0_A = 16'h0006; REQ0_B = 16'h0000; REQ0_FUN = 4'b1101; REQ0_VALID = 1;
    #1;
    n_checks++;
    if (REQ0_READY !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b, required 1", REQ0_READY);
    end
    exp_q.push_back({1'b0, 16'h000C, f_err(flag_ok)});
    @(negedge Clk);
    REQ0_VALID = 0;
    n_checks++;
    if ({ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, ALU_A, ALU_FUN, BUSY} !== {4'b0001, 16'h0006, 2'b01, 1'b1}) begin
      n_fail++; $display("FAIL single_issue: got en=%b A=%h fun=%b busy=%b, required 0001 0006 01 1",
                         {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable}, ALU_A, ALU_FUN, BUSY);
    end
    @(negedge Clk);
    n_checks++;
    if ({ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, RSP0_VALID} !== 5'b0) begin
      n_fail++; $display("FAIL single_capture: got en=%b rsp0=%b, required 0000 0",
                         {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable}, RSP0_VALID);
    end
    @(negedge Clk);
    n_checks++;
    if ({RSP0_VALID, RSP_DATA, OP_COUNT} !== {1'b1, 16'h000C, 16'd1}) begin
      n_fail++; $display("FAIL single_latency: got rsp0=%b data=%h cnt=%h, required 1 000c 0001", RSP0_VALID, RSP_DATA, OP_COUNT);
    end
    @(negedge Clk);
    n_checks++;
    if ({RSP0_VALID, RSP_DATA, BUSY} !== {1'b0, 16'h000C, 1'b0}) begin
      n_fail++; $display("FAIL single_hold: got rsp0=%b data=%h busy=%b, required 0 000c 0", RSP0_VALID, RSP_DATA, BUSY);
    end
  endtask

  task automatic test_req1_only();
    bit to, br;
    ops0.delete(); ops1.delete(); grant_log.delete();
    ops1.push_back({16'h0000, 16'h8000, 4'b1110});
    drive_ops(40, to, br);
    n_checks++;
    if (to || grant_log.size() != 1 || grant_log[0] != 1) begin
      n_fail++; $display("FAIL req1_grant: timeout=%b grants=%0d, required one grant to 1", to, grant_log.size());
    end
    n_checks++;
    if ({RSP_DATA, OP_COUNT} !== {16'h4000, exp_count}) begin
      n_fail++; $display("FAIL req1_result: got data=%h cnt=%h, required 4000 %h", RSP_DATA, OP_COUNT, exp_count);
    end
  endtask

  task automatic test_contention();
    bit         to, br;
    logic [3:0] order;
    ops0.delete(); ops1.delete(); grant_log.delete(); acc_cyc.delete();
    ops0.push_back({16'h1234, 16'h0F0F, 4'b0000});
    ops0.push_back({16'h00F0, 16'h0FF0, 4'b0101});
    ops1.push_back({16'h0005, 16'h0009, 4'b1010});
    ops1.push_back({16'hFFFF, 16'h0001, 4'b0001});
    drive_ops(80, to, br);
    n_checks++;
    if (to || br) begin
      n_fail++; $display("FAIL contention_hs: timeout=%b both_ready=%b, required 0 0", to, br);
    end
    order = 4'hF;
    if (grant_log.size() == 4) order = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
    n_checks++;
    if (order !== 4'b0101) begin
      n_fail++; $display("FAIL contention_order: got %b (%0d grants), required 0101", order, grant_log.size());
    end
    n_checks++;
    if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 9) begin
      n_fail++; $display("FAIL back_to_back: got %0d accepts spanning %0d cycles, required 4 spanning 9",
                         acc_cyc.size(), (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[0] : -1);
    end
    n_checks++;
    if (OP_COUNT !== exp_count) begin
      n_fail++; $display("FAIL contention_count: got %h, required %h", OP_COUNT, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    bit to, br;
    @(negedge Clk);
    REQ0_A = 16'h0003; REQ0_B = 16'h0004; REQ0_FUN = 4'b0000; REQ0_VALID = 1;
    @(negedge Clk);
    REQ0_VALID = 0;
    @(negedge Clk);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL midrst_busy: got %b in capture, required 1", BUSY);
    end
    RST = 0;
    exp_count = '0;
    #1;
    n_checks++;
    if ({BUSY, OP_COUNT, RSP0_VALID, RSP1_VALID} !== 19'd0) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b cnt=%h v0=%b v1=%b, required 0", BUSY, OP_COUNT, RSP0_VALID, RSP1_VALID);
    end
    @(negedge Clk);
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_checks++;
      if ({RSP0_VALID, RSP1_VALID, OP_COUNT} !== 18'd0) begin
        n_fail++; $display("FAIL midrst_norsp: got v0=%b v1=%b cnt=%h, required 0", RSP0_VALID, RSP1_VALID, OP_COUNT);
      end
    end
    ops0.delete(); ops1.delete();
    ops0.push_back({16'h0003, 16'h0004, 4'b0000});
    drive_ops(40, to, br);
    n_checks++;
    if (to || OP_COUNT !== 16'd1 || RSP_DATA !== 16'h0007) begin
      n_fail++; $display("FAIL midrst_next: timeout=%b cnt=%h data=%h, required 0 0001 0007", to, OP_COUNT, RSP_DATA);
    end
  endtask

  task automatic test_flag();
    bit   to, br;
    logic want;
    flag_ok = 0;
    want    = f_err(1'b0);
    ops0.delete(); ops1.delete();
    ops1.push_back({16'h00AA, 16'h0055, 4'b0110});
    drive_ops(40, to, br);
    n_checks++;
    if (to || RSP_ERR !== want || RSP_DATA !== 16'h00FF) begin
      n_fail++; $display("FAIL flag_err: timeout=%b err=%b data=%h, required 0 %b 00ff", to, RSP_ERR, RSP_DATA, want);
    end
    flag_ok = 1;
    ops1.delete();
    ops0.push_back({16'h0009, 16'h0009, 4'b1000});
    drive_ops(40, to, br);
    n_checks++;
    if (to || RSP_ERR !== 1'b0 || RSP_DATA !== 16'h0001) begin
      n_fail++; $display("FAIL flag_ok: timeout=%b err=%b data=%h, required 0 0 0001", to, RSP_ERR, RSP_DATA);
    end
  endtask

  task automatic test_wrap();
    bit to, br;
    @(negedge Clk);
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    exp_count = 16'hFFFF;
    ops0.delete(); ops1.delete();
    ops0.push_back({16'h8001, 16'h0000, 4'b1100});
    drive_ops(40, to, br);
    n_checks++;
    if (to || OP_COUNT !== 16'h0000 || RSP_DATA !== 16'h4000) begin
      n_fail++; $display("FAIL count_wrap: timeout=%b cnt=%h data=%h, required 0 0000 4000", to, OP_COUNT, RSP_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_req1_only();
    test_contention();
    test_reset_mid();
    test_flag();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port round-robin arbiter and sequencer in front of the shared ALU (arithmetic, logic, compare and shift units, each registering its result one clock after its enable).
- Accepts operation requests from two requesters over valid/ready handshakes and decodes the 4-bit function into one unit enable plus a 2-bit sub-function.
- Issues the operation for exactly one cycle, captures the registered unit result, and returns it to the originating requester with a one-cycle response pulse.

## Interface
Parameters:
- DATA_WIDTH, 16, operand and result width.

Ports:
- Clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- REQ0_VALID  input  1  requester 0 has an operation pending.
- REQ0_READY  output  1  requester 0 accepted this cycle.
- REQ0_A, REQ0_B  input  DATA_WIDTH  requester 0 operands.
- REQ0_FUN  input  4  requester 0 function code.
- REQ1_VALID / REQ1_READY / REQ1_A / REQ1_B / REQ1_FUN  same, for requester 1.
- ALU_A, ALU_B  output  DATA_WIDTH  operands to the ALU units.
- ALU_FUN  output  2  sub-function, REQ_FUN[1:0] of the granted request.
- ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  output  1 each  unit enables.
- ALU_OUT  input  DATA_WIDTH  OR of the unit outputs; disabled units drive 0.
- ALU_FLAG  input  1  OR of the unit flags.
- RSP_DATA  output  DATA_WIDTH  captured result.
- RSP0_VALID, RSP1_VALID  output  1 each  one-cycle response pulse to requester 0 / 1.
- RSP_ERR  output  1  valid with RSPn_VALID; see Configuration.
- BUSY  output  1  high when the FSM is not in IDLE.
- OP_COUNT  output  16  count of completed operations.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE. Reset state is IDLE.
- **Unit decode** on REQ_FUN[3:2]:
  - 00 → ARITH
  - 01 → LOGIC
  - 10 → CMP
  - 11 → SHIFT
- **Grant (combinational, IDLE only)**:
  - If exactly one REQn_VALID is high, grant n.
  - If both are high, grant the requester indicated by the priority pointer.
  - REQn_READY = (state==IDLE) && grant==n && REQn_VALID. At most one READY is high in any cycle.
- **Accept edge** (IDLE, with a grant):
  - Latch A, B and FUN of the winner into operand registers; record the winner ID.
  - Set the priority pointer to the other requester.
  - Go to ISSUE.
- **IDLE with no valid requests**: stay in IDLE.
- **ISSUE**:
  - Drive ALU_A, ALU_B and ALU_FUN from the operand registers.
  - Assert exactly one unit enable.
  - Go to CAPTURE.
- **CAPTURE**:
  - All enables are 0.
  - Sample ALU_OUT and ALU_FLAG (the unit's registered result of the ISSUE cycle) into RSP_DATA and the error logic.
  - Pulse RSPn_VALID for the recorded winner in the next cycle.
  - Increment OP_COUNT; it wraps from 0xFFFF to 0x0000.
  - Go to IDLE.
- **Outside ISSUE**: ALU_A, ALU_B and ALU_FUN hold the last issued values; all enables are 0.
- **Requester obligations**: REQn_A, REQn_B and REQn_FUN must be held stable while REQn_VALID is high and READY is low. Once REQn_VALID is high it is not withdrawn until READY.
- **Back-to-back**: a new request can be accepted in the same IDLE cycle in which RSPn_VALID is high.

## Timing
- **Reset values**: REQ0_READY and REQ1_READY follow the combinational IDLE grant, so READY may be high during reset if VALID is high. All other outputs reset to 0: all enables, ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP0_VALID, RSP1_VALID, RSP_ERR, BUSY and OP_COUNT. The priority pointer resets to requester 0.
- **Latency**, with the accept edge as T0:
  - ISSUE cycle T0→T1, unit enable high.
  - CAPTURE cycle T1→T2.
  - RSPn_VALID and RSP_DATA valid in cycle T2→T3.
  - Request-to-response is 3 cycles; maximum throughput is 1 operation per 3 cycles.
- **RSP_DATA** holds its value until the next capture.
- **Reset mid-operation**: the in-flight operation is dropped, no response is issued, and OP_COUNT is not incremented.
- **Fairness**: under continuous contention, grants alternate 0,1,0,1 and neither requester waits more than one operation.

## Configuration
- Macro `ALU_ARB_FLAG_CHECK_EN`.
- Defined: in CAPTURE, RSP_ERR is registered as !ALU_FLAG and is valid alongside RSPn_VALID. An enabled unit that fails to raise its flag is reported as an error.
- Undefined: RSP_ERR is tied to 0 and ALU_FLAG is ignored.

## Test plan
- After reset: all outputs 0. REQ0 asserts A=0x0006, FUN=4'b1101 (SHIFT, A<<1). REQ0_READY is high; SHIFT_Enable is high for exactly one cycle; RSP0_VALID pulses 3 cycles after accept with RSP_DATA=0x000C; OP_COUNT=1.
- Both requesters valid continuously for 4 operations: grants alternate 0,1,0,1; READY is never high for both; each RSPn_VALID matches its own ID and operands.
- REQ1 only, FUN=4'b1110 (B>>1), B=0x8000 → RSP1_VALID with RSP_DATA=0x4000; RSP0_VALID stays 0.
- RST asserted during CAPTURE: no RSP pulse, OP_COUNT=0, FSM in IDLE. The next request completes normally.
- With `ALU_ARB_FLAG_CHECK_EN`: a bench ALU model holds ALU_FLAG=0 → RSP_ERR=1 alongside RSPn_VALID. Without the macro, RSP_ERR stays 0.
- Preload OP_COUNT to 0xFFFF via 65535 operations (or force); the next operation wraps it to 0x0000.
